// File: rtl/cpu_clock.sv
// cpu_clock: derives the CPU clock from sys_clk, either free-running at 2*DIV or
// single-stepped from a debounced push button; a HLT freezes it until rst.
//
// state  | meaning
// LOW    | cpu_clk low; phase counts out the minimum low time, then waits for a rise opportunity
// HIGH   | cpu_clk high for exactly DIV sys_clk cycles
// HALTED | frozen by HLT; only rst leaves this state
module cpu_clock #(
    parameter int DIV             = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic halt,
    input  logic manual_mode,
    input  logic step_btn,
    output logic cpu_clk,
    output logic cpu_clk_rise,
    output logic cpu_clk_fall,
    output logic halted
);
    localparam int PW = $clog2(DIV) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LOW, HIGH, HALTED} state_t;

    logic [1:0]    btn_sync;
    logic [1:0]    mode_sync;
    logic          btn_deb;
    logic [DW-1:0] deb_cnt;
    logic          press;
    state_t        state;
    logic [PW-1:0] phase;
    logic          rise_opp;

    // Synchronisers and debouncer; press is a one-cycle pulse on the debounced 0->1 edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            btn_sync  <= '0;
            mode_sync <= '0;
            btn_deb   <= 1'b0;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            btn_sync  <= {btn_sync[0], step_btn};
            mode_sync <= {mode_sync[0], manual_mode};
            press     <= 1'b0;
            if (btn_sync[1] == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DB_LAST) begin
                btn_deb <= btn_sync[1];
                deb_cnt <= '0;
                press   <= btn_sync[1];
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign rise_opp = (phase == PH_LAST) && (!mode_sync[1] || press);

    // Outputs are registered from the state, so they trail the state by one cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= LOW;
            phase        <= '0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
            cpu_clk_fall <= 1'b0;
            halted       <= 1'b0;
        end else begin
            cpu_clk      <= (state == HIGH);
            cpu_clk_rise <= (state == HIGH) && !cpu_clk;
            cpu_clk_fall <= (state != HIGH) && cpu_clk;
            halted       <= (state == HALTED);
            case (state)
                LOW: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + 1'b1;
                    end else if (rise_opp) begin
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            state <= HIGH;
                            phase <= '0;
                        end
                    end
                end
                HIGH: begin
                    if (phase == PH_LAST) begin
                        state <= LOW;
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= LOW;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clock.sv
// tb_cpu_clock: directed scenarios for cpu_clock at DIV=4, DEBOUNCE_CYCLES=8.
module tb_cpu_clock;
    localparam int DIV = 4;
    localparam int DB  = 8;
    // step_btn edge to cpu_clk rise: 2 sync flops, DB-cycle debounce, press pulse, output register
    localparam int PRESS_TO_RISE = 2 + DB + 2;

    logic sys_clk = 1'b0;
    logic rst, halt, manual_mode, step_btn;
    logic cpu_clk, cpu_clk_rise, cpu_clk_fall, halted;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   base   = 0;
    int   rise_q[$];
    int   fall_q[$];
    logic exp_clk    = 1'b0;
    logic exp_halted = 1'b0;

    cpu_clock #(.DIV(DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .halt         (halt),
        .manual_mode  (manual_mode),
        .step_btn     (step_btn),
        .cpu_clk      (cpu_clk),
        .cpu_clk_rise (cpu_clk_rise),
        .cpu_clk_fall (cpu_clk_fall),
        .halted       (halted)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One sys_clk cycle; outputs sampled on the falling edge against expected pulses due this cycle.
    task automatic tick();
        logic er, ef;
        @(negedge sys_clk);
        cyc++;
        er = 1'b0;
        ef = 1'b0;
        if (rise_q.size() > 0 && rise_q[0] == cyc) begin
            er = 1'b1;
            exp_clk = 1'b1;
            void'(rise_q.pop_front());
        end
        if (fall_q.size() > 0 && fall_q[0] == cyc) begin
            ef = 1'b1;
            exp_clk = 1'b0;
            void'(fall_q.pop_front());
        end
        check($sformatf("outputs@%0d(rise,fall,clk,halted)", cyc),
              {28'd0, cpu_clk_rise, cpu_clk_fall, cpu_clk, halted},
              {28'd0, er, ef, exp_clk, exp_halted});
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_clk = 1'b0;
        exp_halted = 1'b0;
        rise_q.delete();
        fall_q.delete();
        ticks(3);
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic push_periods(input int first_rise, input int n);
        for (int i = 0; i < n; i++) begin
            rise_q.push_back(first_rise + 2 * DIV * i);
            fall_q.push_back(first_rise + DIV + 2 * DIV * i);
        end
    endtask

    task automatic check_drained(input string tag);
        check(tag, 32'(rise_q.size() + fall_q.size()), 32'd0);
    endtask

    initial begin
        int fall2;
        rst = 1'b1;
        halt = 1'b0;
        manual_mode = 1'b0;
        step_btn = 1'b0;

        // Free-run: first rise on the (DIV+1)-th edge after rst released, then 4 high / 4 low.
        do_reset();
        check("reset_cpu_clk", 32'(cpu_clk), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        push_periods(base + DIV + 1, 10);
        run_to(base + DIV + 1 + 2 * DIV * 9 + DIV);
        check_drained("s1_ten_periods");
        check("s1_clk_low_after_last_fall", 32'(cpu_clk), 32'd0);

        // Halt sampled at the rise opportunity of period 2.
        do_reset();
        push_periods(base + DIV + 1, 2);
        fall2 = base + DIV + 1 + 2 * DIV + DIV;
        run_to(fall2 + 2);
        halt = 1'b1;
        run_to(fall2 + DIV - 1);
        exp_halted = 1'b1;
        tick();
        check("s2_halted_when_rise_due", 32'(halted), 32'd1);
        for (int i = 0; i < 200; i++) begin
            halt        = 1'($urandom_range(0, 1));
            manual_mode = 1'($urandom_range(0, 1));
            step_btn    = 1'($urandom_range(0, 1));
            tick();
        end
        check("s2_still_halted", 32'(halted), 32'd1);
        check("s2_clk_frozen", 32'(cpu_clk), 32'd0);
        check_drained("s2_no_rise_after_halt");
        halt = 1'b0;
        manual_mode = 1'b0;
        step_btn = 1'b0;
        do_reset();
        check("s2_unhalted_by_rst", 32'(halted), 32'd0);
        push_periods(base + DIV + 1, 2);
        run_to(base + DIV + 1 + 2 * DIV + DIV);
        check_drained("s2_free_run_resumes");

        // Single-step with a bouncy button: only the final stable press yields a pulse.
        manual_mode = 1'b1;
        do_reset();
        run_to(base + 10);
        for (int i = 0; i < 15; i++) begin
            step_btn = ((i / 3) % 2 == 0);
            if (i == 12) begin
                rise_q.push_back(cyc + PRESS_TO_RISE);
                fall_q.push_back(cyc + PRESS_TO_RISE + DIV);
            end
            tick();
        end
        ticks(30);
        step_btn = 1'b0;
        ticks(30);
        check_drained("s3_bounce_single_pulse");
        rise_q.push_back(cyc + PRESS_TO_RISE);
        fall_q.push_back(cyc + PRESS_TO_RISE + DIV);
        step_btn = 1'b1;
        ticks(20);
        step_btn = 1'b0;
        ticks(30);
        check_drained("s3_second_clean_press");

        // A press landing in a high phase is dropped and does not stretch it.
        manual_mode = 1'b0;
        do_reset();
        push_periods(base + DIV + 1, 2);
        run_to(base + 4);
        step_btn = 1'b1;
        run_to(base + 14);
        manual_mode = 1'b1;
        run_to(base + 60);
        check_drained("s4_press_in_high_dropped");
        step_btn = 1'b0;
        ticks(20);
        rise_q.push_back(cyc + PRESS_TO_RISE);
        fall_q.push_back(cyc + PRESS_TO_RISE + DIV);
        step_btn = 1'b1;
        ticks(20);
        step_btn = 1'b0;
        ticks(20);
        check_drained("s4_later_press_works");

        // Mode change mid-high: that phase stays 4 cycles, then no rise without a press.
        manual_mode = 1'b0;
        do_reset();
        push_periods(base + DIV + 1, 2);
        run_to(base + 14);
        manual_mode = 1'b1;
        run_to(base + 17 + 100);
        check_drained("s5_mode_change_mid_high");
        check("s5_clk_idle_low", 32'(cpu_clk), 32'd0);

        // Reset in the 2nd cycle of a high phase: clock drops at once, no fall pulse.
        manual_mode = 1'b0;
        do_reset();
        push_periods(base + DIV + 1, 2);
        run_to(base + 14);
        check("s6_clk_high_before_rst", 32'(cpu_clk), 32'd1);
        do_reset();
        check("s6_clk_low_after_rst", 32'(cpu_clk), 32'd0);
        push_periods(base + DIV + 1, 3);
        run_to(base + DIV + 1 + 2 * DIV * 2 + DIV);
        check_drained("s6_restart_timing");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_clock.md
Name: cpu_clock

Overview:
- Generates the CPU clock `cpu_clk` from the FPGA system clock.
- Sits directly upstream of the control unit and all CPU registers; `cpu_clk` drives their clock inputs.
- Consumes the control unit's `clk_halt`.
- Two modes: free-running divided clock, or single-step from a debounced push button. A HLT instruction freezes the clock permanently until reset.

Parameters:
- DIV, 4, high-phase and low-phase length in sys_clk cycles (≥1); free-run period = 2*DIV.
- DEBOUNCE_CYCLES, 8, consecutive stable sys_clk cycles required to accept a button level change (≥1).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- halt  in  1  clk_halt from the control unit; asserted while the HLT microstep is decoded.
- manual_mode  in  1  asynchronous switch: 1 = single-step, 0 = free-run.
- step_btn  in  1  raw asynchronous push button, bouncy, active-high.
- cpu_clk  out  1  CPU clock, registered.
- cpu_clk_rise  out  1  high for exactly the first sys_clk cycle in which cpu_clk=1.
- cpu_clk_fall  out  1  high for exactly the first sys_clk cycle in which cpu_clk=0 after a high phase.
- halted  out  1  sticky: clock frozen by HLT.

Behaviour:
- Reset values: cpu_clk=0, cpu_clk_rise=0, cpu_clk_fall=0, halted=0. Also state=LOW, phase counter=0, synchronisers=0, debounced button=0, debounce counter=0. rst wins over every other event, including mid-high-phase: cpu_clk=0 the cycle after rst is sampled.
- Input conditioning: step_btn and manual_mode each pass through a 2-flop synchroniser.
  - Debounce counter: counts while synced step_btn differs from the debounced level; clears when they match.
  - At DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A press event is a single-cycle 0→1 transition of the debounced level.
  - Press latency ≈ 2 + DEBOUNCE_CYCLES cycles.
- Phase counter: width $clog2(DIV)+1; counts 0..DIV-1 and saturates at DIV-1 in LOW.
- States:
  - LOW: cpu_clk=0. Counter increments to DIV-1 (minimum low time). A "rise opportunity" exists when the counter is at DIV-1 and either:
    - free-run: manual_mode_sync=0; or
    - single-step: manual_mode_sync=1 and a press event occurs in that cycle.
    
    On a rise opportunity:
    - if halt=1 → HALTED;
    - else → HIGH, counter=0, cpu_clk=1 and cpu_clk_rise=1 on the next cycle.
    
    Press events in LOW before the counter reaches DIV-1 are dropped.
  - HIGH: cpu_clk=1 for exactly DIV sys_clk cycles. Counter increments; at DIV-1 → LOW, counter=0, cpu_clk_fall=1 on the next cycle. Press events in HIGH are dropped. A mode change does not shorten or extend the current high phase.
  - HALTED: cpu_clk=0, halted=1. halt, press events and mode changes are ignored; only rst exits.
- Halt timing: the control unit changes microstep on the falling cpu_clk edge, so halt is evaluated only at a rise opportunity. halt toggling during HIGH, or in LOW before DIV-1, has no effect.
- Mode switch: manual_mode_sync is sampled only at the counter=DIV-1 point in LOW.
- Free-run timing: cpu_clk first goes high on the (DIV+1)-th sys_clk edge after rst is first sampled low. Steady state: period 2*DIV, 50% duty.
- Pulse outputs: cpu_clk_rise and cpu_clk_fall are never asserted together, and never for more than 1 cycle.

Test Plan (DIV=4, DEBOUNCE_CYCLES=8):
1. Free-run: rst for 3 cycles, manual_mode=0, halt=0 → cpu_clk high 4 / low 4 repeatedly; cpu_clk_rise pulses exactly 8 cycles apart; 10 periods checked.
2. Halt: assert halt at the 3rd low-phase cycle of period 2 → no further rise; halted=1 at the cycle the rise was due; cpu_clk stays 0 for 200 cycles with halt toggling. Then rst → halted=0 and free-run resumes.
3. Single-step with bounce: manual_mode=1; step_btn toggles every 3 cycles for 15 cycles, then held high for 30 → exactly one 4-cycle high pulse. Release and press cleanly again → a second pulse.
4. Dropped presses: manual_mode=1; a second clean press while cpu_clk is high → no additional pulse; high phase still exactly 4 cycles.
5. Mode change mid-high: in free-run, set manual_mode=1 during a high phase → that high phase lasts 4 cycles; no further rise for 100 cycles without a press.
6. Reset mid-operation: rst in the 2nd cycle of a high phase → cpu_clk=0 next cycle; no cpu_clk_fall pulse; restart timing matches scenario 1.
